// File: rtl/tff_counter_pkg.sv
// Shared constants and count arithmetic for tff_counter.
// TFF_COUNTER_SAT_EN selects saturation at the bounds instead of wrapping.
package tff_counter_pkg;

  localparam int WIDTH_MAX = 16;

  function automatic logic [WIDTH_MAX-1:0] clamp_mod(input logic [WIDTH_MAX-1:0] value,
                                                     input int unsigned mod);
    logic [WIDTH_MAX-1:0] top_v;
    top_v = WIDTH_MAX'(mod - 1);
    clamp_mod = (value >= top_v) ? top_v : value;
  endfunction

  function automatic logic [WIDTH_MAX-1:0] next_count(input logic [WIDTH_MAX-1:0] count,
                                                      input logic up,
                                                      input int unsigned mod);
    logic [WIDTH_MAX-1:0] top_v;
    top_v = WIDTH_MAX'(mod - 1);
    if (up) begin
`ifdef TFF_COUNTER_SAT_EN
      next_count = (count >= top_v) ? top_v : count + 16'd1;
`else
      next_count = (count >= top_v) ? '0 : count + 16'd1;
`endif
    end else begin
`ifdef TFF_COUNTER_SAT_EN
      next_count = (count == '0) ? '0 : count - 16'd1;
`else
      next_count = (count == '0) ? top_v : count - 16'd1;
`endif
    end
  endfunction

endpackage

// File: rtl/tff_counter_cell.sv
// Single toggle flip-flop: Q inverts on a clock edge when T is high.
module toggle_cell
  import tff_counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  assign q_d = q_q ^ t_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/tff_counter.sv
// Modulo-MOD up/down counter held in a bank of toggle cells; drives their T inputs.
// Build option TFF_COUNTER_SAT_EN: saturate at 0 / MOD-1 instead of wrapping.
module tff_counter
  import tff_counter_pkg::*;
#(
  parameter int          WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc
);

  logic [WIDTH_MAX-1:0] cnt_ext;
  logic [WIDTH_MAX-1:0] nxt_ext;
  logic [WIDTH-1:0]     count_d;
  logic                 tc_d;
  logic                 tc_q;
  logic                 unused_hi;

  // The bound check is the same for wrap and saturate; only next_count differs.
  always_comb begin
    cnt_ext = WIDTH_MAX'(count);
    nxt_ext = cnt_ext;
    tc_d    = 1'b0;
    if (load) begin
      nxt_ext = clamp_mod(WIDTH_MAX'(load_val), MOD);
    end else if (en) begin
      nxt_ext = next_count(cnt_ext, up, MOD);
      tc_d    = up ? (cnt_ext == WIDTH_MAX'(MOD - 1)) : (cnt_ext == '0);
    end
    count_d = WIDTH'(nxt_ext);
    t_vec   = count ^ count_d;
  end

  assign unused_hi = ^nxt_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tc_q <= 1'b0;
    else       tc_q <= tc_d;
  end

  assign tc = tc_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    toggle_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t_i   (t_vec[i]),
      .q_o   (count[i])
    );
  end

endmodule
